// File: rtl/iagc_pkg.sv
// Shared IAGC status codes and default loop thresholds.
// The status codes are also decoded by the ADC wrapper.
package iagc_pkg;

   localparam int ZMOD_DATA_SIZE_DEF   = 14;
   localparam int IAGC_STATUS_SIZE_DEF = 4;

   localparam logic [3:0] IAGC_STATUS_RESET   = 4'b0000;
   localparam logic [3:0] IAGC_STATUS_INIT    = 4'b0001;
   localparam logic [3:0] IAGC_STATUS_SETTLE  = 4'b0010;
   localparam logic [3:0] IAGC_STATUS_MEASURE = 4'b0011;
   localparam logic [3:0] IAGC_STATUS_DECIDE  = 4'b0100;
   localparam logic [3:0] IAGC_STATUS_ERROR   = 4'b1111;

   localparam int WINDOW_LOG2_DEF   = 10;
   localparam int RESET_HOLD_DEF    = 16;
   localparam int INIT_TIMEOUT_DEF  = 65536;
   localparam int SETTLE_DEF        = 1024;
   localparam int HIGH_THRESH_DEF   = 7000;
   localparam int LOW_THRESH_DEF    = 1500;

endpackage

// File: rtl/iagc_peak_detector.sv
// Windowed peak-magnitude detector with saturating abs.
// done strobes combinationally on the last sample of a window.
module iagc_peak_detector
   import iagc_pkg::*;
#(
   parameter int DATA_W      = ZMOD_DATA_SIZE_DEF,
   parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-2:0] peak,
   output logic [DATA_W-2:0] peak_next,
   output logic              done
);

   logic [DATA_W-1:0]      abs_full;
   logic [DATA_W-2:0]      mag;
   logic [WINDOW_LOG2-1:0] cnt;

   // Only the most negative code overflows; it saturates to full scale.
   always_comb begin
      abs_full  = sample[DATA_W-1] ? (~sample + 1'b1) : sample;
      mag       = abs_full[DATA_W-1] ? '1 : abs_full[DATA_W-2:0];
      peak_next = (mag > peak) ? mag : peak;
      done      = en && (cnt == '1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak <= '0;
         cnt  <= '0;
      end else if (clear) begin
         peak <= '0;
         cnt  <= '0;
      end else if (en) begin
         peak <= peak_next;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/iagc_gain_sequencer.sv
// Closed-loop channel-1 gain controller; re-sequences the ADC
// (hold, init, settle) on every gain change.
module iagc_gain_sequencer
   import iagc_pkg::*;
#(
   parameter int ZMOD_DATA_SIZE      = ZMOD_DATA_SIZE_DEF,
   parameter int IAGC_STATUS_SIZE    = IAGC_STATUS_SIZE_DEF,
   parameter int WINDOW_LOG2         = WINDOW_LOG2_DEF,
   parameter int RESET_HOLD_CYCLES   = RESET_HOLD_DEF,
   parameter int INIT_TIMEOUT_CYCLES = INIT_TIMEOUT_DEF,
   parameter int SETTLE_CYCLES       = SETTLE_DEF,
   parameter int HIGH_THRESH         = HIGH_THRESH_DEF,
   parameter int LOW_THRESH          = LOW_THRESH_DEF
) (
   input  logic                             i_sys_clock,
   input  logic                             i_reset_n,
   input  logic                             i_enable,
   input  logic                             i_sample_valid,
   input  logic signed [ZMOD_DATA_SIZE-1:0] i_sample,
   input  logic                             i_adc_init_done,
   output logic [IAGC_STATUS_SIZE-1:0]      o_iagc_status,
   output logic                             o_gain_high,
   output logic [ZMOD_DATA_SIZE-2:0]        o_peak,
   output logic                             o_busy,
   output logic                             o_error
);

   localparam int M1    = (RESET_HOLD_CYCLES > SETTLE_CYCLES) ?
                          RESET_HOLD_CYCLES : SETTLE_CYCLES;
   localparam int CMAX  = (M1 > INIT_TIMEOUT_CYCLES) ?
                          M1 : INIT_TIMEOUT_CYCLES;
   localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int PK_W  = ZMOD_DATA_SIZE - 1;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [PK_W-1:0]  HI_TH       = PK_W'(HIGH_THRESH);
   localparam logic [PK_W-1:0]  LO_TH       = PK_W'(LOW_THRESH);

   logic [3:0]       state;
   logic [3:0]       nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             gain_nxt;
   logic             pd_clear;
   logic             pd_en;
   logic             win_done;
   logic [PK_W-1:0]  acc_peak;
   logic [PK_W-1:0]  acc_next;

   assign pd_clear = (state != IAGC_STATUS_MEASURE);
   assign pd_en    = (state == IAGC_STATUS_MEASURE) && i_enable &&
                     i_sample_valid;

   iagc_peak_detector #(
      .DATA_W      (ZMOD_DATA_SIZE),
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) u_peak (
      .clk       (i_sys_clock),
      .rst_n     (i_reset_n),
      .clear     (pd_clear),
      .en        (pd_en),
      .sample    (i_sample),
      .peak      (acc_peak),
      .peak_next (acc_next),
      .done      (win_done)
   );

   always_comb begin
      nxt      = state;
      cnt_nxt  = cnt;
      gain_nxt = o_gain_high;
      if (!i_enable) begin
         nxt     = IAGC_STATUS_RESET;
         cnt_nxt = '0;
      end else begin
         case (state)
            IAGC_STATUS_RESET: begin
               if (cnt == HOLD_LAST) begin
                  nxt     = IAGC_STATUS_INIT;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            IAGC_STATUS_INIT: begin
               if (i_adc_init_done) begin
                  nxt     = IAGC_STATUS_SETTLE;
                  cnt_nxt = '0;
               end else if (cnt == INIT_LAST) begin
                  nxt     = IAGC_STATUS_ERROR;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            IAGC_STATUS_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  nxt     = IAGC_STATUS_MEASURE;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            IAGC_STATUS_MEASURE: begin
               if (win_done) nxt = IAGC_STATUS_DECIDE;
            end
            IAGC_STATUS_DECIDE: begin
               // Thresholds are 4x apart in gain, so one switch cannot bounce back.
               if (o_gain_high && (o_peak >= HI_TH)) begin
                  gain_nxt = 1'b0;
                  nxt      = IAGC_STATUS_RESET;
               end else if (!o_gain_high && (o_peak < LO_TH)) begin
                  gain_nxt = 1'b1;
                  nxt      = IAGC_STATUS_RESET;
               end else begin
                  nxt = IAGC_STATUS_MEASURE;
               end
               cnt_nxt = '0;
            end
            IAGC_STATUS_ERROR: nxt = IAGC_STATUS_ERROR;
            default: begin
               nxt     = IAGC_STATUS_RESET;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= IAGC_STATUS_RESET;
         cnt         <= '0;
         o_gain_high <= 1'b0;
         o_peak      <= '0;
         o_busy      <= 1'b1;
         o_error     <= 1'b0;
      end else begin
         state       <= nxt;
         cnt         <= cnt_nxt;
         o_gain_high <= gain_nxt;
         o_busy      <= (nxt != IAGC_STATUS_MEASURE);
         o_error     <= (nxt == IAGC_STATUS_ERROR);
         if (win_done) o_peak <= acc_next;
      end
   end

   assign o_iagc_status = IAGC_STATUS_SIZE'(state);

endmodule

// File: tb/tb_iagc_gain_sequencer.sv
// Directed bench for the IAGC gain sequencer.
// Outputs are sampled 1 time unit after the rising edge.
module tb_iagc_gain_sequencer;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              valid;
   logic signed [13:0] sample;
   logic              init_done;
   logic [3:0]        status;
   logic              gain_high;
   logic [12:0]       peak;
   logic              busy;
   logic              error;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   iagc_gain_sequencer dut (
      .i_sys_clock     (clk),
      .i_reset_n       (rst_n),
      .i_enable        (enable),
      .i_sample_valid  (valid),
      .i_sample        (sample),
      .i_adc_init_done (init_done),
      .o_iagc_status   (status),
      .o_gain_high     (gain_high),
      .o_peak          (peak),
      .o_busy          (busy),
      .o_error         (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_len(input logic [3:0] code, input int bound,
                          output int n);
      n = 0;
      while (status === code && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_measure();
      int n;
      n = 0;
      while (status !== 4'b0011 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (status !== 4'b0011)
         $display("FAIL reach_measure status=%b required=0011", status);
      else passes++;
   endtask

   task automatic send_window(input int amp, input int sidx, input int sval);
      for (int i = 0; i < 1024; i++) begin
         valid = 1'b1;
         if (i == sidx) sample = 14'(sval);
         else if (i % 2 == 1) sample = 14'(-amp);
         else sample = 14'(amp);
         tick();
      end
      valid  = 1'b0;
      sample = '0;
   endtask

   task automatic check_decide(input string nm, input logic [12:0] pk,
                               input logic g);
      checks++;
      if (status !== 4'b0100)
         $display("FAIL %s_decide status=%b required=0100", nm, status);
      else passes++;
      checks++;
      if (peak !== pk)
         $display("FAIL %s_peak peak=%0d required=%0d", nm, peak, pk);
      else passes++;
      checks++;
      if (gain_high !== g)
         $display("FAIL %s_gain_pre gain=%b required=%b", nm, gain_high, g);
      else passes++;
   endtask

   task automatic check_after(input string nm, input logic [3:0] st,
                              input logic g);
      tick();
      checks++;
      if (status !== st)
         $display("FAIL %s_next status=%b required=%b", nm, status, st);
      else passes++;
      checks++;
      if (gain_high !== g)
         $display("FAIL %s_gain gain=%b required=%b", nm, gain_high, g);
      else passes++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; valid = 1'b0;
      sample = '0; init_done = 1'b0;
      #12;
      checks++;
      if ({status, gain_high, peak, busy, error} !== {4'b0000, 1'b0, 13'd0, 1'b1, 1'b0})
         $display("FAIL reset_values st=%b g=%b pk=%0d busy=%b err=%b required=0000/0/0/1/0",
                  status, gain_high, peak, busy, error);
      else passes++;
   endtask

   task automatic test_startup();
      int n;
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      run_len(4'b0000, 100, n);
      checks++;
      if (n !== 16) $display("FAIL hold_len cycles=%0d required=16", n);
      else passes++;
      repeat (39) tick();
      checks++;
      if (status !== 4'b0001)
         $display("FAIL init_wait status=%b required=0001", status);
      else passes++;
      init_done = 1'b1;
      tick();
      checks++;
      if (status !== 4'b0010)
         $display("FAIL init_exit status=%b required=0010", status);
      else passes++;
      checks++;
      if (busy !== 1'b1) $display("FAIL settle_busy busy=%b required=1", busy);
      else passes++;
      run_len(4'b0010, 2000, n);
      checks++;
      if (n !== 1024) $display("FAIL settle_len cycles=%0d required=1024", n);
      else passes++;
      checks++;
      if (status !== 4'b0011 || busy !== 1'b0)
         $display("FAIL measure_entry status=%b busy=%b required=0011/0",
                  status, busy);
      else passes++;
   endtask

   task automatic test_low_to_high();
      send_window(1000, -1, 0);
      check_decide("low1000", 13'd1000, 1'b0);
      check_after("low1000", 4'b0000, 1'b1);
      wait_measure();
      send_window(5000, -1, 0);
      check_decide("high5000", 13'd5000, 1'b1);
      check_after("high5000", 4'b0011, 1'b1);
   endtask

   task automatic test_high_saturate();
      send_window(0, 7, -8192);
      check_decide("sat", 13'd8191, 1'b1);
      check_after("sat", 4'b0000, 1'b0);
      wait_measure();
   endtask

   task automatic test_low_threshold();
      send_window(0, 100, 1500);
      check_decide("at1500", 13'd1500, 1'b0);
      check_after("at1500", 4'b0011, 1'b0);
      send_window(0, 200, -1499);
      check_decide("at1499", 13'd1499, 1'b0);
      check_after("at1499", 4'b0000, 1'b1);
      wait_measure();
   endtask

   task automatic test_enable_drop();
      int n;
      repeat (10) begin
         valid  = 1'b1;
         sample = 14'sd3000;
         tick();
      end
      valid  = 1'b0;
      enable = 1'b0;
      tick();
      checks++;
      if ({status, gain_high, peak, busy} !== {4'b0000, 1'b1, 13'd1499, 1'b1})
         $display("FAIL drop_measure st=%b g=%b pk=%0d busy=%b required=0000/1/1499/1",
                  status, gain_high, peak, busy);
      else passes++;
      enable = 1'b1;
      run_len(4'b0000, 100, n);
      checks++;
      if (n !== 16) $display("FAIL rehold_len cycles=%0d required=16", n);
      else passes++;
      tick();
      checks++;
      if (status !== 4'b0010)
         $display("FAIL reinit status=%b required=0010", status);
      else passes++;
      repeat (100) tick();
      enable = 1'b0;
      tick();
      checks++;
      if (status !== 4'b0000 || gain_high !== 1'b1)
         $display("FAIL drop_settle st=%b g=%b required=0000/1",
                  status, gain_high);
      else passes++;
      enable = 1'b1;
      run_len(4'b0000, 100, n);
      checks++;
      if (n !== 16) $display("FAIL rehold2_len cycles=%0d required=16", n);
      else passes++;
      wait_measure();
      send_window(2000, -1, 0);
      check_decide("restart", 13'd2000, 1'b1);
      check_after("restart", 4'b0011, 1'b1);
   endtask

   task automatic test_timeout();
      int n;
      enable    = 1'b0;
      init_done = 1'b0;
      tick();
      enable = 1'b1;
      run_len(4'b0000, 100, n);
      checks++;
      if (n !== 16) $display("FAIL to_hold_len cycles=%0d required=16", n);
      else passes++;
      run_len(4'b0001, 70000, n);
      checks++;
      if (n !== 65536) $display("FAIL init_timeout cycles=%0d required=65536", n);
      else passes++;
      checks++;
      if ({status, error, busy} !== {4'b1111, 1'b1, 1'b1})
         $display("FAIL error_state st=%b err=%b busy=%b required=1111/1/1",
                  status, error, busy);
      else passes++;
      repeat (5) tick();
      checks++;
      if (status !== 4'b1111 || error !== 1'b1)
         $display("FAIL error_sticky st=%b err=%b required=1111/1",
                  status, error);
      else passes++;
      enable = 1'b0;
      tick();
      checks++;
      if (status !== 4'b0000 || error !== 1'b0)
         $display("FAIL error_clear st=%b err=%b required=0000/0",
                  status, error);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_low_to_high();
      test_high_saturate();
      test_low_threshold();
      test_enable_drop();
      test_timeout();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/iagc_gain_sequencer.md
Name: iagc_gain_sequencer

Overview:
Closed-loop gain controller for the Zmod ADC1410 channel-1 path. It drives the 4-bit IAGC status word that the ADC wrapper decodes; status 0000 holds the ADC controller in reset. It also drives the channel-1 gain-select relay. The block measures the peak sample magnitude over fixed windows and switches between high and low gain with hysteresis. On every gain change it re-sequences the ADC: reset, then initialisation, then settling.

Parameters:
ZMOD_DATA_SIZE, 14, ADC sample width (two's complement).
IAGC_STATUS_SIZE, 4, status word width.
WINDOW_LOG2, 10, measurement window is 2^WINDOW_LOG2 valid samples.
RESET_HOLD_CYCLES, 16, cycles status is held at 0000 before initialisation.
INIT_TIMEOUT_CYCLES, 65536, maximum wait for ADC init done.
SETTLE_CYCLES, 1024, cycles after init done during which samples are discarded.
HIGH_THRESH, 7000, peak magnitude at or above which high gain is abandoned.
LOW_THRESH, 1500, peak magnitude below which low gain is abandoned; must be less than HIGH_THRESH/4 to guarantee hysteresis.

Ports:
i_sys_clock  in  1  system clock.
i_reset_n  in  1  asynchronous, active-low reset.
i_enable  in  1  run request; low forces the idle/reset state.
i_sample_valid  in  1  i_sample qualifier, one sample per asserted cycle.
i_sample  in  ZMOD_DATA_SIZE  channel-1 ADC sample, signed.
i_adc_init_done  in  1  ADC controller init complete, active high.
o_iagc_status  out  IAGC_STATUS_SIZE  sequencer status word to the ADC wrapper.
o_gain_high  out  1  1 = high gain, 0 = low gain.
o_peak  out  ZMOD_DATA_SIZE-1  peak magnitude of the last completed window.
o_busy  out  1  high in every state except MEASURE.
o_error  out  1  sticky init-timeout flag.

Behaviour:
- Reset values: o_iagc_status=0000, o_gain_high=0, o_peak=0, o_busy=1, o_error=0, all counters 0, state HOLD.
- States and status codes:
  - HOLD 0000
  - INIT 0001
  - SETTLE 0010
  - MEASURE 0011
  - DECIDE 0100
  - ERROR 1111
- All outputs are registered. o_iagc_status always equals the code of the current state.
- HOLD: count i_enable-high cycles. After RESET_HOLD_CYCLES consecutive such cycles, go to INIT. While i_enable=0, the counter is held at 0.
- INIT:
  - i_adc_init_done=1 → SETTLE, counter cleared.
  - Otherwise, after INIT_TIMEOUT_CYCLES cycles → ERROR.
- SETTLE: ignore samples. After SETTLE_CYCLES cycles → MEASURE, with peak accumulator and sample counter cleared.
- MEASURE:
  - On each i_sample_valid, compute magnitude = |i_sample|. The magnitude is 13 bits; -8192 saturates to 8191.
  - Update peak = max(peak, magnitude) and increment the sample counter.
  - On the 2^WINDOW_LOG2-th valid sample → DECIDE. That sample is included in the peak, and o_peak loads the final peak on the same edge.
- DECIDE (exactly one cycle):
  - gain_high=1 and o_peak>=HIGH_THRESH → gain_high←0, then HOLD.
  - gain_high=0 and o_peak<LOW_THRESH → gain_high←1, then HOLD.
  - Otherwise → MEASURE with the accumulator cleared. Samples arriving during DECIDE are dropped.
- ERROR: o_error=1. Leave only when i_enable=0, which goes to HOLD and clears o_error.
- i_enable=0 in any state: next state HOLD, counters cleared. o_gain_high and o_peak are retained.
- Simultaneous events:
  - i_enable=0 has priority over every other transition.
  - In INIT, init_done and timeout on the same cycle resolve to SETTLE.
- i_adc_init_done is treated as already synchronous to i_sys_clock; no synchroniser is inside the block.
- Loop latency: a gain change costs RESET_HOLD + init time + SETTLE + one full window before the next decision.

Decomposition:
- Shared package iagc_pkg holds:
  - the status/state codes (IAGC_STATUS_RESET=0000 through IAGC_STATUS_ERROR=1111), shared with the ADC wrapper;
  - the default threshold constants.
- One sub-module: iagc_peak_detector. It contains the abs/saturate, max accumulator, window counter and window-done strobe, with clear and enable inputs.

Test Plan:
1. Reset, i_enable=1, i_adc_init_done rises 40 cycles after entering INIT → status 0000 for 16 cycles, then 0001 for 40 cycles, then 0010 for 1024 cycles, then 0011. o_busy drops on entering MEASURE.
2. Low gain, window of samples with amplitude ±1000 → o_peak=1000, o_gain_high goes 1, status returns to 0000. A following window at ±5000 → no change, measurement continues.
3. High gain, one window sample of -8192 and the rest 0 → o_peak=8191, o_gain_high goes 0, re-sequence starts from 0000.
4. i_adc_init_done held 0 → status 1111 after 65536 INIT cycles with o_error=1. i_enable pulsed low → o_error=0 and status 0000.
5. i_enable deasserted mid-MEASURE and mid-SETTLE → status 0000 on the next edge, gain and peak retained. Re-enable restarts the full sequence.
6. Sample with value 1500 in low gain → no switch (exactly at threshold). Value 1499 → switch.
